axi_write_slave: RTL



---
 rtl/axi_pkg.sv | 25 ++
 rtl/axi_addr_gen.sv | 18 +
 rtl/axi_write_slave.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared burst/response codes, FSM states and size decode for the AXI write slave
package axi_pkg;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] SIZE_1B      = 2'b00;
   localparam logic [1:0] SIZE_2B      = 2'b01;
   localparam logic [1:0] SIZE_4B      = 2'b10;
   localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_RESP = 2'd2
   } wr_state_t;

   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction
endpackage

// File: rtl/axi_addr_gen.sv
// rtl/axi_addr_gen.sv - next beat address from current address, beat size and burst type
module axi_addr_gen
   import axi_pkg::*;
#(
   parameter int BUSWIDTH = 32
)(
   input  logic [BUSWIDTH-1:0] addr,
   input  logic [1:0]          size,
   input  logic [1:0]          burst,
   output logic [BUSWIDTH-1:0] next_addr
);
   // WRAP and reserved bursts step like INCR; no wrap boundary is applied
   always_comb begin
      next_addr = addr + BUSWIDTH'(size_bytes(size));
      if (burst == BURST_FIXED)
         next_addr = addr;
   end
endmodule

// File: rtl/axi_write_slave.sv
// rtl/axi_write_slave.sv - AXI write slave to single-cycle memory write port; AXI_WR_SLVERR_EN enables SLVERR checks
module axi_write_slave
   import axi_pkg::*;
#(
   parameter int BUSWIDTH   = 32,
   parameter int SLAVE_TAGS = 2
)(
   input  logic                    ACLK,
   input  logic                    ARESET,
   input  logic [SLAVE_TAGS-1:0]   AWID,
   input  logic [BUSWIDTH-1:0]     AWADDR,
   input  logic [3:0]              AWLEN,
   input  logic [1:0]              AWSIZE,
   input  logic [1:0]              AWBURST,
   input  logic [1:0]              AWLOCK,
   input  logic [3:0]              AWCACHE,
   input  logic [2:0]              AWPROT,
   input  logic                    AWVALID,
   output logic                    AWREADY,
   input  logic [SLAVE_TAGS-1:0]   WID,
   input  logic [BUSWIDTH-1:0]     WDATA,
   input  logic [BUSWIDTH/8-1:0]   WSTRB,
   input  logic                    WLAST,
   input  logic                    WVALID,
   output logic                    WREADY,
   output logic [SLAVE_TAGS-1:0]   BID,
   output logic [1:0]              BRESP,
   output logic                    BVALID,
   input  logic                    BREADY,
   output logic [BUSWIDTH-1:0]     address_out,
   output logic [BUSWIDTH-1:0]     data_out,
   output logic [BUSWIDTH/8-1:0]   strb_out,
   output logic                    memwrite
);
   wr_state_t           state;
   logic [BUSWIDTH-1:0] cur_addr;
   logic [BUSWIDTH-1:0] next_addr;
   logic [3:0]          len_q;
   logic [3:0]          beat_cnt;
   logic [1:0]          size_q;
   logic [1:0]          burst_q;
   logic                aw_hs;
   logic                w_hs;
   logic                last_by_count;
   logic                burst_end;
   logic [1:0]          resp_next;
   logic                unused_ok;

   assign aw_hs         = (state == ST_IDLE) && AWREADY && AWVALID;
   assign w_hs          = (state == ST_DATA) && WREADY && WVALID;
   assign last_by_count = (beat_cnt == len_q);
   assign burst_end     = w_hs && (WLAST || last_by_count);
   assign unused_ok     = ^{AWLOCK, AWCACHE, AWPROT, WID};

   axi_addr_gen #(.BUSWIDTH(BUSWIDTH)) u_addr_gen (
      .addr      (cur_addr),
      .size      (size_q),
      .burst     (burst_q),
      .next_addr (next_addr)
   );

`ifdef AXI_WR_SLVERR_EN
   logic err_q;
   logic beat_err;

   // a WLAST that does not line up with the announced length is an error either way
   assign beat_err  = (WID != BID) || (WLAST != last_by_count);
   assign resp_next = (err_q || beat_err) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET)
         err_q <= 1'b0;
      else if (aw_hs)
         err_q <= (AWSIZE == SIZE_ILLEGAL) || (AWBURST == BURST_RSVD);
      else if (w_hs)
         err_q <= err_q || beat_err;
   end
`else
   assign resp_next = RESP_OKAY;
`endif

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state       <= ST_IDLE;
         AWREADY     <= 1'b0;
         WREADY      <= 1'b0;
         BVALID      <= 1'b0;
         BID         <= '0;
         BRESP       <= RESP_OKAY;
         memwrite    <= 1'b0;
         address_out <= '0;
         data_out    <= '0;
         strb_out    <= '0;
         cur_addr    <= '0;
         len_q       <= '0;
         beat_cnt    <= '0;
         size_q      <= '0;
         burst_q     <= '0;
      end else begin
         memwrite <= 1'b0;
         case (state)
            ST_IDLE: begin
               AWREADY <= 1'b1;
               if (aw_hs) begin
                  AWREADY  <= 1'b0;
                  WREADY   <= 1'b1;
                  BID      <= AWID;
                  cur_addr <= AWADDR;
                  len_q    <= AWLEN;
                  size_q   <= AWSIZE;
                  burst_q  <= AWBURST;
                  beat_cnt <= '0;
                  state    <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_hs) begin
                  address_out <= cur_addr;
                  data_out    <= WDATA;
                  strb_out    <= WSTRB;
                  memwrite    <= 1'b1;
                  cur_addr    <= next_addr;
                  beat_cnt    <= beat_cnt + 4'd1;
               end
               if (burst_end) begin
                  WREADY <= 1'b0;
                  BVALID <= 1'b1;
                  BRESP  <= resp_next;
                  state  <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (BVALID && BREADY) begin
                  BVALID  <= 1'b0;
                  AWREADY <= 1'b1;
                  state   <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
